// File: rtl/shifter_pkg.sv
// shifter_pkg: shared definitions for the serial deserializer (shifter_deser).
//   DIR_LEFT / DIR_RIGHT : shift-direction encodings of i_leftRight.
//   state_t              : shift-side FSM encoding (ST_PAR is only reachable
//                          when SHIFTER_DESER_PARITY_EN is defined).
package shifter_pkg;

  // 0 = MSB-first (shift left, new bit enters bit 0)
  // 1 = LSB-first (shift right, new bit enters bit NOBIT-1)
  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_PAR   = 2'd2
  } state_t;

endpackage

// File: rtl/deser_bitcnt.sv
// deser_bitcnt: bit counter for the deserializer.
//   i_clk     : clock
//   i_clr     : asynchronous active-high reset (count -> 0)
//   i_restart : word-boundary restart; count -> 1 if i_inc, else 0
//   i_inc     : count one bit this cycle
//   o_term    : the bit counted this cycle is the NOBIT-th of the word
//               (count == NOBIT-1 while incrementing, no restart)
module deser_bitcnt #(
  parameter int NOBIT = 8,
  parameter int CNTW  = 6
) (
  input  logic i_clk,
  input  logic i_clr,
  input  logic i_restart,
  input  logic i_inc,
  output logic o_term
);

  logic [CNTW-1:0] cnt;

  assign o_term = i_inc && !i_restart && (cnt == CNTW'(NOBIT - 1));

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      cnt <= '0;
    end else if (i_restart) begin
      // A restart bit is itself bit 1 of the new word.
      cnt <= i_inc ? CNTW'(1) : '0;
    end else if (o_term) begin
      cnt <= '0;
    end else if (i_inc) begin
      cnt <= cnt + CNTW'(1);
    end
  end

endmodule

// File: rtl/shifter_deser.sv
// shifter_deser: serial-to-parallel receiver with a one-word output holding
// register.
//
// Optional feature macro: SHIFTER_DESER_PARITY_EN
//   defined   : an even-parity bit follows each NOBIT-bit word (ST_PAR);
//               the word is delivered on the parity-bit edge and o_parErr
//               reports (^word) ^ parity_bit.
//   undefined : no ST_PAR, o_parErr tied to 0.
//
// Ports:
//   i_clk        clock, rising edge
//   i_clr        asynchronous active-high reset
//   i_bit        serial data bit, consumed when i_bitVld=1
//   i_bitVld     i_bit qualifier
//   i_sync       word restart: discards any partial word; with i_bitVld the
//                bit in that cycle becomes bit 1 of a new word
//   i_leftRight  direction, latched on the first bit of each word
//   o_data       completed word (holding register)
//   o_dataVld    o_data holds an unconsumed word
//   i_dataRdy    consumer ready
//   o_busy       a partial word is being assembled (registered)
//   o_ovf        sticky overflow (word completed while holding reg full)
//   i_ovfClr     synchronous clear of o_ovf (a same-edge overflow wins)
//   o_parErr     parity error for the word in o_data
//   o_state      shift-side FSM state, for observation
//
// Handshake: a word transfers on an edge where o_dataVld=1 and i_dataRdy=1.
// o_dataVld, once set, stays high with o_data stable until that transfer;
// a word completing on the transfer edge is loaded with no bubble.
module shifter_deser
  import shifter_pkg::*;
#(
  parameter int NOBIT = 8,
  parameter int CNTW  = 6
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_bit,
  input  logic             i_bitVld,
  input  logic             i_sync,
  input  logic             i_leftRight,
  output logic [NOBIT-1:0] o_data,
  output logic             o_dataVld,
  input  logic             i_dataRdy,
  output logic             o_busy,
  output logic             o_ovf,
  input  logic             i_ovfClr,
  output logic             o_parErr,
  output state_t           o_state
);

  state_t           state;
  logic [NOBIT-1:0] sreg;
  logic             dir;

  logic             first_bit;
  logic             dir_eff;
  logic [NOBIT-1:0] base;
  logic [NOBIT-1:0] shifted;
  logic             cnt_inc;
  logic             cnt_term;
  logic             load;
  logic [NOBIT-1:0] load_word;
  logic             accept;
  logic             overflow;

  assign o_state = state;

  // The first bit of a word (from IDLE or via i_sync) uses the live
  // direction and an empty register; later bits use the latched direction.
  always_comb begin
    first_bit = i_sync || (state == ST_IDLE);
    dir_eff   = first_bit ? i_leftRight : dir;
    base      = first_bit ? '0 : sreg;
    if (dir_eff == DIR_RIGHT) begin
      shifted = {i_bit, base[NOBIT-1:1]};
    end else begin
      shifted = {base[NOBIT-2:0], i_bit};
    end
  end

  // The parity bit is not a data bit, so it does not advance the counter.
  assign cnt_inc = i_bitVld && (i_sync || (state != ST_PAR));

  deser_bitcnt #(
    .NOBIT(NOBIT),
    .CNTW (CNTW)
  ) u_bitcnt (
    .i_clk    (i_clk),
    .i_clr    (i_clr),
    .i_restart(i_sync),
    .i_inc    (cnt_inc),
    .o_term   (cnt_term)
  );

`ifdef SHIFTER_DESER_PARITY_EN
  logic load_perr;
  assign load      = i_bitVld && !i_sync && (state == ST_PAR);
  assign load_word = sreg;
  assign load_perr = (^sreg) ^ i_bit;
`else
  assign load      = cnt_term;
  assign load_word = shifted;
  assign o_parErr  = 1'b0;
`endif

  assign accept   = load && (!o_dataVld || i_dataRdy);
  assign overflow = load && o_dataVld && !i_dataRdy;

  always_ff @(posedge i_clk or posedge i_clr) begin
    if (i_clr) begin
      state     <= ST_IDLE;
      sreg      <= '0;
      dir       <= DIR_LEFT;
      o_busy    <= 1'b0;
      o_data    <= '0;
      o_dataVld <= 1'b0;
      o_ovf     <= 1'b0;
`ifdef SHIFTER_DESER_PARITY_EN
      o_parErr  <= 1'b0;
`endif
    end else begin
      // Shift side
      if (i_sync) begin
        if (i_bitVld) begin
          sreg   <= shifted;
          dir    <= i_leftRight;
          state  <= ST_SHIFT;
          o_busy <= 1'b1;
        end else begin
          sreg   <= '0;
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
      end else if (i_bitVld) begin
        case (state)
          ST_IDLE: begin
            sreg   <= shifted;
            dir    <= i_leftRight;
            state  <= ST_SHIFT;
            o_busy <= 1'b1;
          end
          ST_SHIFT: begin
            sreg <= shifted;
            if (cnt_term) begin
`ifdef SHIFTER_DESER_PARITY_EN
              state  <= ST_PAR;
              o_busy <= 1'b1;
`else
              state  <= ST_IDLE;
              o_busy <= 1'b0;
`endif
            end
          end
          default: begin
            // ST_PAR: this bit is the parity bit; the word leaves here.
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end
        endcase
      end

      // Output side
      if (accept) begin
        o_data    <= load_word;
        o_dataVld <= 1'b1;
`ifdef SHIFTER_DESER_PARITY_EN
        o_parErr  <= load_perr;
`endif
      end else if (o_dataVld && i_dataRdy) begin
        o_dataVld <= 1'b0;
      end

      if (overflow) begin
        o_ovf <= 1'b1;
      end else if (i_ovfClr) begin
        o_ovf <= 1'b0;
      end
    end
  end

endmodule
